// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Parity checking is enabled by defining PS2_RX_PARITY_CHK_EN.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;

    localparam int PS2_FILTER_LEN  = 8;
    localparam int PS2_TIMEOUT_CYC = 50000;

endpackage

// File: rtl/ps2_pin_filter.sv
// Synchronises the PS/2 pins and glitch-filters the clock line.
// Emits a one-cycle strobe on each filtered falling clock edge.
module ps2_pin_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_s;
    logic [1:0]    data_s;
    logic [CW-1:0] cnt;

    assign data_sync = data_s[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s    <= 2'b11;
            data_s   <= 2'b11;
            cnt      <= '0;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            data_s <= {data_s[0], ps2_data};
            fall   <= 1'b0;
            // Level must stay different for FILTER_LEN cycles to be accepted
            if (clk_s[1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                clk_filt <= clk_s[1];
                cnt      <= '0;
                fall     <= ~clk_s[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: framing FSM, watchdog and F0/E0 prefix folding.
// Define PS2_RX_PARITY_CHK_EN to reject frames with bad odd parity.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC,
    parameter int TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    logic            clk_filt;
    logic            data;
    logic            fall;
    logic            sample;
    logic            timeout;
    logic            frame_ok;
    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [TO_W-1:0] wd;
    logic            brk_pend;
    logic            ext_pend;

    ps2_pin_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_filt (clk_filt),
        .data_sync(data),
        .fall     (fall)
    );

    // The strobe is only meaningful while the filtered clock sits low
    assign sample  = fall & ~clk_filt;
    assign timeout = (state != ST_IDLE) && !sample && (wd == TO_MAX);

`ifdef PS2_RX_PARITY_CHK_EN
    logic par;
    assign frame_ok = data & (^{shreg, par});
`else
    assign frame_ok = data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd <= '0;
        end else if (state == ST_IDLE || sample || wd == TO_MAX) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
`ifdef PS2_RX_PARITY_CHK_EN
            par        <= 1'b0;
`endif
            code       <= 8'h00;
            code_valid <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            frame_err  <= 1'b0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                brk_pend  <= 1'b0;
                ext_pend  <= 1'b0;
            end else if (sample) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!data) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_RX_PARITY_CHK_EN
                        par   <= data;
`endif
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                            brk_pend  <= 1'b0;
                            ext_pend  <= 1'b0;
                        end else if (shreg == PS2_PREFIX_EXT) begin
                            ext_pend <= 1'b1;
                        end else if (shreg == PS2_PREFIX_BRK) begin
                            brk_pend <= 1'b1;
                        end else begin
                            code       <= shreg;
                            code_valid <= 1'b1;
                            is_break   <= brk_pend;
                            is_ext     <= ext_pend;
                            brk_pend   <= 1'b0;
                            ext_pend   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: framing, prefixes, errors, glitch,
// watchdog and mid-frame reset.
module tb_ps2_rx_frame;

    localparam int FL  = 8;
    localparam int TO  = 1000;
    localparam int HP  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int nvalid = 0;
    int nerr = 0;
    int both = 0;
    int v0;
    int e0;
    logic [7:0] cap_code = 8'h00;
    logic       cap_brk = 1'b0;
    logic       cap_ext = 1'b0;

    ps2_rx_frame #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO),
        .TO_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .code_valid(code_valid),
        .is_break  (is_break),
        .is_ext    (is_ext),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) begin
            nvalid++;
            cap_code = code;
            cap_brk  = is_break;
            cap_ext  = is_ext;
        end
        if (frame_err) nerr++;
        if (code_valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(HP);
        ps2_clk = 1'b0;
        cyc(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip,
                        input logic stop);
        logic p;
        p = ~(^b) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        ps2_data = 1'b1;
        cyc(2 * HP);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(b[i]);
    endtask

    task automatic snap();
        v0 = nvalid;
        e0 = nerr;
    endtask

    initial begin
        cyc(5);
        chk("rst_code", 32'(code), 32'h00);
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_brk", 32'(is_break), 0);
        chk("rst_ext", 32'(is_ext), 0);
        chk("rst_err", 32'(frame_err), 0);
        rst = 1'b1;
        cyc(5);

        snap();
        send(8'h1C, 1'b0, 1'b1);
        chk("good_cnt", 32'(nvalid - v0), 1);
        chk("good_code", 32'(cap_code), 32'h1C);
        chk("good_brk", 32'(cap_brk), 0);
        chk("good_ext", 32'(cap_ext), 0);
        chk("good_err", 32'(nerr - e0), 0);

        snap();
        send(8'hF0, 1'b0, 1'b1);
        send(8'h2D, 1'b0, 1'b1);
        chk("brk_cnt", 32'(nvalid - v0), 1);
        chk("brk_code", 32'(cap_code), 32'h2D);
        chk("brk_flag", 32'(cap_brk), 1);
        chk("brk_ext", 32'(cap_ext), 0);
        send(8'h2D, 1'b0, 1'b1);
        chk("mk_cnt", 32'(nvalid - v0), 2);
        chk("mk_brk", 32'(cap_brk), 0);

        snap();
        send(8'hE0, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b1);
        send(8'h75, 1'b0, 1'b1);
        chk("xb_cnt", 32'(nvalid - v0), 1);
        chk("xb_code", 32'(cap_code), 32'h75);
        chk("xb_ext", 32'(cap_ext), 1);
        chk("xb_brk", 32'(cap_brk), 1);
        send(8'h1C, 1'b0, 1'b1);
        chk("xb_next", 32'({cap_ext, cap_brk}), 0);
        chk("xb_err", 32'(nerr - e0), 0);

        snap();
        send(8'h29, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_CHK_EN
        chk("par_err", 32'(nerr - e0), 1);
        chk("par_cnt", 32'(nvalid - v0), 0);
`else
        chk("par_err", 32'(nerr - e0), 0);
        chk("par_cnt", 32'(nvalid - v0), 1);
        chk("par_code", 32'(cap_code), 32'h29);
`endif

        snap();
        send(8'h34, 1'b0, 1'b0);
        chk("stop_err", 32'(nerr - e0), 1);
        chk("stop_cnt", 32'(nvalid - v0), 0);

        snap();
        ps2_data = 1'b0;
        cyc(HP);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(HP);
        ps2_data = 1'b1;
        cyc(4 * HP);
        chk("glitch_cnt", 32'(nvalid - v0), 0);
        chk("glitch_err", 32'(nerr - e0), 0);
        send(8'h1C, 1'b0, 1'b1);
        chk("glitch_next", 32'(nvalid - v0), 1);
        chk("glitch_code", 32'(cap_code), 32'h1C);

        snap();
        send_partial(8'hA5, 4);
        ps2_data = 1'b1;
        cyc(TO + 100);
        chk("to_err", 32'(nerr - e0), 1);
        chk("to_cnt", 32'(nvalid - v0), 0);
        send(8'h16, 1'b0, 1'b1);
        chk("to_next", 32'(nvalid - v0), 1);
        chk("to_code", 32'(cap_code), 32'h16);
        chk("to_err2", 32'(nerr - e0), 1);

        snap();
        send_partial(8'h5A, 5);
        rst = 1'b0;
        ps2_data = 1'b1;
        cyc(3);
        chk("mr_code", 32'(code), 32'h00);
        chk("mr_out", 32'({code_valid, is_break, is_ext, frame_err}), 0);
        rst = 1'b1;
        cyc(4 * HP);
        chk("mr_quiet", 32'((nvalid - v0) + (nerr - e0)), 0);
        send(8'h1E, 1'b0, 1'b1);
        chk("mr_cnt", 32'(nvalid - v0), 1);
        chk("mr_code2", 32'(cap_code), 32'h1E);
        chk("mr_err", 32'(nerr - e0), 0);

        chk("never_both", 32'(both), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
